nwc_job_scheduler: RTL
======================

# nwc_job_scheduler

Sequencer and arbiter that shares one `nwc_top` negacyclic-convolution engine between `NUM_REQ` host requesters. It accepts jobs (input bank, output bank, tag) and grants them round-robin. It drives the BRAM bank selects for the granted job, issues the `start` pulse only when the engine is ready, and detects job completion from the engine's sticky `done`. It then returns a tagged completion to the owning requester. It sits between the host/DMA front end and `nwc_top` plus its BRAM bank muxes.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8)
- `BANK_W`, 2: width of a BRAM bank-pair select
- `TAG_W`, 4: job tag width
- `TIMEOUT_CYCLES`, 65536: watchdog limit for the LOAD and COMPUTE states together
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req_valid`  in  NUM_REQ  job request per requester
- `req_ready`  out  NUM_REQ  one-hot accept; a job transfers on `req_valid[i] & req_ready[i]`
- `req_in_bank`  in  NUM_REQ*BANK_W  input bank pair per requester; slice i belongs to requester i
- `req_out_bank`  in  NUM_REQ*BANK_W  output bank pair per requester
- `req_tag`  in  NUM_REQ*TAG_W  job tag per requester
- `cpl_valid`  out  NUM_REQ  one-cycle completion pulse to the owning requester
- `cpl_tag`  out  TAG_W  tag of the completing job; valid with `cpl_valid`
- `cpl_error`  out  1  completion was caused by the watchdog; valid with `cpl_valid`
- `nwc_start`  out  1  start pulse to the engine, registered
- `nwc_ready`  in  1  engine ready
- `nwc_done`  in  1  engine done (sticky level)
- `in_bank_sel`  out  BANK_W  read-side bank mux select
- `out_bank_sel`  out  BANK_W  write-side bank mux select
- `grant_id`  out  $clog2(NUM_REQ)  current owner
- `busy`  out  1  high in every state except IDLE

## Operation
- States: IDLE, WAIT_RDY, START, LOAD, COMPUTE, CPL, FAULT.
- IDLE:
  - The arbiter picks the first valid requester at or after `rr_ptr`, wrapping.
  - `req_ready` is asserted for that requester in the same cycle. It is combinational from `req_valid` and `rr_ptr`.
  - Bank selects, tag and `grant_id` are captured, then the FSM moves to WAIT_RDY.
  - If no requester is valid, the FSM stays in IDLE.
- WAIT_RDY: when `nwc_ready`=1, go to START. This state has no timeout.
- START: `nwc_start`=1 for exactly this one cycle, then go to LOAD.
- LOAD: wait for `nwc_ready`=0, which means the engine accepted the start. Then go to COMPUTE.
- COMPUTE: wait for a rising edge of `nwc_done` (`nwc_done & ~done_q`). A level left high by the previous job must not count as completion. Then go to CPL.
- CPL:
  - Pulse `cpl_valid[grant_id]` with `cpl_tag` and `cpl_error`=0.
  - Set `rr_ptr` to `grant_id+1` mod `NUM_REQ`.
  - Go to IDLE.
- Watchdog:
  - The counter clears on entry to LOAD and increments in LOAD and COMPUTE.
  - At `TIMEOUT_CYCLES-1` it pulses `cpl_valid[grant_id]` with `cpl_error`=1 and enters FAULT.
- FAULT is sticky until `rst_n`=0: `busy`=1, all `req_ready`=0, `nwc_start`=0.
- `in_bank_sel`, `out_bank_sel` and `grant_id` hold constant from capture through CPL. They hold their last value in IDLE.
- `done_q` samples `nwc_done` every cycle, including in IDLE.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0, `done_q` 0, watchdog 0.
  - Outputs `nwc_start` 0, `cpl_valid` 0, `cpl_tag` 0, `cpl_error` 0, bank selects 0, `grant_id` 0, `busy` 0.
- A reset mid-job returns the FSM to IDLE next cycle with no completion issued. The engine has no reset, so its state is the host's concern.
- Request accept to `nwc_start`: 2 cycles when `nwc_ready` is already high (IDLE→WAIT_RDY→START).
- The engine's `ready` falls 1 cycle after it samples `start` and stays low for about 2048 load cycles plus compute. LOAD therefore normally lasts 1–2 cycles.
- Completion: `cpl_valid` is asserted 1 cycle after the `nwc_done` rising edge is seen. The next grant is possible the cycle after `cpl_valid`.
- A request from the requester that just completed is not favoured: the other valid requester wins.
- `req_valid` dropping while not granted is legal. A granted request is consumed in the grant cycle.

## Structure
- Package `nwc_sched_pkg`: state enum, defaults for `BANK_W`/`TAG_W`, constant `NWC_WORDS`=2048.
- Sub-module `rr_arbiter`: parameterised by `NUM_REQ`. Inputs are `req` and `ptr`; outputs are a one-hot grant and an index, both combinational.

## Test plan
- Single job: requester 0 sends tag 5, in bank 1, out bank 2. The engine model gives `ready` low 1 cycle after start and a `done` rise 3000 cycles later. Expected: one `nwc_start` pulse, bank selects 1/2 held throughout, `cpl_valid[0]` with tag 5 and error 0.
- Contention: both requesters are valid continuously with tags 1 and 2. Grants must alternate 0,1,0,1 over 4 jobs, with no back-to-back `nwc_start` before each completion.
- Sticky done: `nwc_done` stays high from the previous job into the next one. The scheduler must not complete until `done` falls and rises again.
- Engine busy: the engine holds `nwc_ready`=0 for 50 cycles after grant. Expected: `nwc_start` is asserted exactly 1 cycle after `ready` rises, and never earlier.
- Watchdog: with `TIMEOUT_CYCLES`=100, `done` never rises. Expected: `cpl_valid` with error 1 at cycle 99 after LOAD entry, then FAULT with `req_ready`=0 until reset.
- Reset mid-COMPUTE: `rst_n` low for 1 cycle. Expected: next cycle is IDLE with `busy`=0, no `cpl_valid`, and `rr_ptr`=0.

Source files
------------

// File: rtl/nwc_sched_pkg.sv
// Shared types and constants for the negacyclic-convolution job scheduler.
package nwc_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_START,
    S_LOAD,
    S_COMPUTE,
    S_CPL,
    S_FAULT
  } state_e;

  localparam int DEF_BANK_W = 2;
  localparam int DEF_TAG_W  = 4;
  localparam int NWC_WORDS  = 2048;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping.
// Grant and index are purely combinational.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic        found;
  int unsigned cand;

  // NOTE: every output and temporary gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/nwc_job_scheduler.sv
// Shares one nwc_top engine between NUM_REQ requesters: round-robin grant,
// bank-select steering, start handshake, done-edge completion and watchdog.
module nwc_job_scheduler
  import nwc_sched_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int BANK_W         = DEF_BANK_W,
  parameter int TAG_W          = DEF_TAG_W,
  parameter int TIMEOUT_CYCLES = 32 * NWC_WORDS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*BANK_W-1:0]   req_in_bank,
  input  logic [NUM_REQ*BANK_W-1:0]   req_out_bank,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  output logic [NUM_REQ-1:0]          cpl_valid,
  output logic [TAG_W-1:0]            cpl_tag,
  output logic                        cpl_error,
  output logic                        nwc_start,
  input  logic                        nwc_ready,
  input  logic                        nwc_done,
  output logic [BANK_W-1:0]           in_bank_sel,
  output logic [BANK_W-1:0]           out_bank_sel,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);

  localparam int GID_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d, grant_q, grant_d;
  logic [BANK_W-1:0]  in_bank_q, in_bank_d, out_bank_q, out_bank_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic               done_q, start_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [GID_W-1:0]   arb_idx;
  logic [BANK_W-1:0]  sel_in, sel_out;
  logic [TAG_W-1:0]   sel_tag;
  logic               done_rise, wdog_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(GID_W)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    sel_in  = '0;
    sel_out = '0;
    sel_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_in  = req_in_bank[i*BANK_W +: BANK_W];
        sel_out = req_out_bank[i*BANK_W +: BANK_W];
        sel_tag = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // A done level left over from the previous job must not complete this one.
  assign done_rise = nwc_done & ~done_q;
  assign wdog_hit  = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    in_bank_d  = in_bank_q;
    out_bank_d = out_bank_q;
    tag_d      = tag_q;
    wdog_d     = wdog_q;
    req_ready  = '0;
    cpl_valid  = '0;
    cpl_error  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = arb_gnt;
        if (|req_valid) begin
          grant_d    = arb_idx;
          in_bank_d  = sel_in;
          out_bank_d = sel_out;
          tag_d      = sel_tag;
          state_d    = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: if (nwc_ready) state_d = S_START;
      S_START: begin
        wdog_d  = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        wdog_d = wdog_q + 1'b1;
        if (wdog_hit) begin
          cpl_valid[grant_q] = 1'b1;
          cpl_error          = 1'b1;
          state_d            = S_FAULT;
        end else if (!nwc_ready) begin
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        wdog_d = wdog_q + 1'b1;
        if (done_rise) begin
          state_d = S_CPL;
        end else if (wdog_hit) begin
          cpl_valid[grant_q] = 1'b1;
          cpl_error          = 1'b1;
          state_d            = S_FAULT;
        end
      end
      S_CPL: begin
        cpl_valid[grant_q] = 1'b1;
        rr_ptr_d = (grant_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d  = S_IDLE;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register updates from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      in_bank_q  <= '0;
      out_bank_q <= '0;
      tag_q      <= '0;
      wdog_q     <= '0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      in_bank_q  <= in_bank_d;
      out_bank_q <= out_bank_d;
      tag_q      <= tag_d;
      wdog_q     <= wdog_d;
      done_q     <= nwc_done;
      start_q    <= (state_d == S_START);
    end
  end

  assign nwc_start    = start_q;
  assign cpl_tag      = tag_q;
  assign in_bank_sel  = in_bank_q;
  assign out_bank_sel = out_bank_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q != S_IDLE);

endmodule
